xbar_out_mux: RTL and testbench

- Per-output-port data path of the stream crossbar. Sits directly downstream of the per-output round-robin arbiter.
- Takes the arbiter's one-hot grant vector, locks onto the granted source for a whole packet, and muxes that source's AXI-Stream beats through a 2-entry output buffer.
- Returns back-pressure only to the locked source and pulses an accepted-last strobe that the arbiter uses to advance.
- Enforces a maximum packet length by forced termination.

---
 rtl/xbar_out_mux.sv | 213 +++++++++++++++++++++
 tb/tb_xbar_out_mux.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_out_mux.sv
// -----------------------------------------------------------------------------
// xbar_out_mux
//
// Per-output-port data path of the stream crossbar. It sits behind the
// round-robin arbiter of one output port. When the arbiter grants a source,
// this block locks onto that source for one whole packet. It then moves the
// source's AXI-Stream beats through a 2-entry output buffer.
//
// Packets are bounded to MAX_PACKETS beats. The beat that reaches the limit
// is marked last and the lock is released. Any remaining beats from that
// source form a new packet on its next grant.
//
// Handshake rule (both sides): a beat transfers in a cycle where valid and
// ready are both high. Ready never depends on valid on the same interface.
//
// Ports
//   clk, rst_n   clock and synchronous active-low reset
//   grant_i      one-hot grant from the arbiter (sampled only in IDLE)
//   s_tvalid_i   per-source valid
//   s_tdata_i    per-source data, source k at [k*DATA_WIDTH +: DATA_WIDTH]
//   s_tlast_i    per-source last
//   s_tready_o   per-source ready, only the locked source can be high
//   s_last_o     strobe when the locked source's packet terminates
//                (goes to the arbiter's last input)
//   m_tvalid_o   output valid
//   m_tdata_o    output data
//   m_tlast_o    output last
//   m_tid_o      output source index
//   m_tready_i   output ready
//   busy_o       high while locked onto a source
//   trunc_o      pulse when a packet is cut at MAX_PACKETS beats
// -----------------------------------------------------------------------------
module xbar_out_mux #(
   parameter int  NUM_REQUEST = 4,
   parameter int  DATA_WIDTH  = 32,
   parameter int  MAX_PACKETS = 8,
   localparam int SEL_W       = $clog2(NUM_REQUEST)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQUEST-1:0]            grant_i,
   input  logic [NUM_REQUEST-1:0]            s_tvalid_i,
   input  logic [NUM_REQUEST*DATA_WIDTH-1:0] s_tdata_i,
   input  logic [NUM_REQUEST-1:0]            s_tlast_i,
   output logic [NUM_REQUEST-1:0]            s_tready_o,
   output logic [NUM_REQUEST-1:0]            s_last_o,
   output logic                              m_tvalid_o,
   output logic [DATA_WIDTH-1:0]             m_tdata_o,
   output logic                              m_tlast_o,
   output logic [SEL_W-1:0]                  m_tid_o,
   input  logic                              m_tready_i,
   output logic                              busy_o,
   output logic                              trunc_o
);

   localparam int               CNT_W    = $clog2(MAX_PACKETS) + 1;
   // Beat count at which the beat being accepted is the MAX_PACKETS-th one.
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(MAX_PACKETS - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t                 state_q;
   logic [SEL_W-1:0]       sel_q;
   logic [CNT_W-1:0]       beat_cnt_q;

   // 2-entry FIFO: payload (no reset) plus pointers and occupancy.
   logic [DATA_WIDTH-1:0]  fifo_data_q [2];
   logic [SEL_W-1:0]       fifo_id_q   [2];
   logic [1:0]             fifo_last_q;
   logic                   wr_ptr_q;
   logic                   rd_ptr_q;
   logic [1:0]             count_q;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic [SEL_W-1:0]       grant_idx;
   logic                   src_valid;
   logic                   src_last;
   logic [DATA_WIDTH-1:0]  src_data;
   logic                   buf_ready;
   logic                   accept;
   logic                   max_hit;
   logic                   term;
   logic                   consume;

   // Lowest set grant bit wins. Scanning from the top and letting the later
   // (lower) index overwrite gives that priority. It also defines behaviour
   // for an illegal multi-hot grant.
   always_comb begin
      grant_idx = '0;
      for (int i = NUM_REQUEST - 1; i >= 0; i--) begin
         if (grant_i[i]) begin
            grant_idx = SEL_W'(i);
         end
      end
   end

   // Select the locked source's signals. The compare-based mux keeps an
   // out-of-range sel (non power-of-two NUM_REQUEST) harmless.
   always_comb begin
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_data  = '0;
      for (int k = 0; k < NUM_REQUEST; k++) begin
         if (sel_q == SEL_W'(k)) begin
            src_valid = s_tvalid_i[k];
            src_last  = s_tlast_i[k];
            src_data  = s_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign buf_ready = (state_q == ST_LOCKED) && (count_q != 2'd2);
   assign accept    = buf_ready && src_valid;
   assign max_hit   = (beat_cnt_q == TERM_CNT);
   assign term      = src_last || max_hit;
   assign consume   = (count_q != 2'd0) && m_tready_i;

   // ---------------------------------------------------------------------
   // Lock FSM and beat counter
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_i != '0) begin
                  sel_q      <= grant_idx;
                  beat_cnt_q <= '0;
                  state_q    <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               // Grant is ignored here. Leaving on a terminating accept
               // guarantees one IDLE cycle before the next lock.
               if (accept) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
                  if (term) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Output buffer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (accept) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (consume) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({accept, consume})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset. Occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_data_q[wr_ptr_q] <= src_data;
         fifo_id_q[wr_ptr_q]   <= sel_q;
         fifo_last_q[wr_ptr_q] <= term;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: every output is forced to zero while reset is held
   // ---------------------------------------------------------------------
   always_comb begin
      s_tready_o = '0;
      s_last_o   = '0;
      for (int k = 0; k < NUM_REQUEST; k++) begin
         if (sel_q == SEL_W'(k)) begin
            s_tready_o[k] = rst_n && buf_ready;
            s_last_o[k]   = rst_n && accept && term;
         end
      end
   end

   // Forced termination only: a beat that is already marked last is not
   // counted as a truncation.
   assign trunc_o    = rst_n && accept && max_hit && !src_last;
   assign busy_o     = rst_n && (state_q == ST_LOCKED);
   assign m_tvalid_o = rst_n && (count_q != 2'd0);
   assign m_tdata_o  = rst_n ? fifo_data_q[rd_ptr_q] : '0;
   assign m_tlast_o  = rst_n && fifo_last_q[rd_ptr_q];
   assign m_tid_o    = rst_n ? fifo_id_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_xbar_out_mux.sv
// -----------------------------------------------------------------------------
// tb_xbar_out_mux
//
// Self-checking bench for xbar_out_mux. It has three parts:
//   - a directed vector table for a single packet;
//   - hand-written multi-cycle sequences: back-pressure, isolation,
//     truncation and reset mid-packet;
//   - randomized traffic.
//
// Every cycle is also checked against a queue-based reference model. The
// model knows only the rules for lock, ready, termination and buffer
// behaviour.
// -----------------------------------------------------------------------------
module tb_xbar_out_mux;

   localparam int NR   = 4;
   localparam int DW   = 32;
   localparam int MAXP = 8;
   localparam int SW   = $clog2(NR);

   // ---------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------
   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     s_tvalid;
   logic [NR*DW-1:0]  s_tdata;
   logic [NR-1:0]     s_tlast;
   logic [NR-1:0]     s_tready;
   logic [NR-1:0]     s_last;
   logic              m_tvalid;
   logic [DW-1:0]     m_tdata;
   logic              m_tlast;
   logic [SW-1:0]     m_tid;
   logic              m_tready;
   logic              busy;
   logic              trunc;

   always #5 clk = ~clk;

   xbar_out_mux #(
      .NUM_REQUEST (NR),
      .DATA_WIDTH  (DW),
      .MAX_PACKETS (MAXP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .grant_i    (grant),
      .s_tvalid_i (s_tvalid),
      .s_tdata_i  (s_tdata),
      .s_tlast_i  (s_tlast),
      .s_tready_o (s_tready),
      .s_last_o   (s_last),
      .m_tvalid_o (m_tvalid),
      .m_tdata_o  (m_tdata),
      .m_tlast_o  (m_tlast),
      .m_tid_o    (m_tid),
      .m_tready_i (m_tready),
      .busy_o     (busy),
      .trunc_o    (trunc)
   );

   // ---------------------------------------------------------------------
   // Scoreboard state and reference model
   // ---------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [SW-1:0] id;
   } beat_t;

   beat_t mq[$];            // beats expected on the m side, in order
   bit    md_locked = 0;
   int    md_sel    = 0;
   int    md_beats  = 0;
   bit    mdl_acc   = 0;    // model's view: beat accepted this cycle

   // Observation counters used by the directed sequences
   int trunc_obs = 0;
   int last_obs  = 0;
   int del_obs   = 0;
   int iso_watch = -1;
   int iso_viol  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare the DUT with the model for the current cycle's inputs, then
   // advance the model past the coming clock edge.
   task automatic model_step();
      logic [NR-1:0] e_rdy  = '0;
      logic [NR-1:0] e_sl   = '0;
      logic          e_mv   = 1'b0;
      logic          e_ml   = 1'b0;
      logic          e_tr   = 1'b0;
      logic          e_busy = 1'b0;
      logic [DW-1:0] e_md   = '0;
      logic [SW-1:0] e_id   = '0;
      bit            acc    = 0;
      bit            term   = 0;
      beat_t         nb;
      if (rst_n) begin
         e_busy = md_locked;
         if (mq.size() > 0) begin
            e_mv = 1'b1;
            e_md = mq[0].data;
            e_ml = mq[0].last;
            e_id = mq[0].id;
         end
         if (md_locked && mq.size() < 2) e_rdy[md_sel] = 1'b1;
         acc  = md_locked && (mq.size() < 2) && s_tvalid[md_sel];
         term = s_tlast[md_sel] || (md_beats + 1 == MAXP);
         if (acc && term) e_sl[md_sel] = 1'b1;
         if (acc && !s_tlast[md_sel] && (md_beats + 1 == MAXP)) e_tr = 1'b1;
      end
      chk("s_tready_o", 64'(s_tready), 64'(e_rdy));
      chk("s_last_o",   64'(s_last),   64'(e_sl));
      chk("m_tvalid_o", 64'(m_tvalid), 64'(e_mv));
      chk("busy_o",     64'(busy),     64'(e_busy));
      chk("trunc_o",    64'(trunc),    64'(e_tr));
      if (!rst_n || e_mv) begin
         chk("m_tdata_o", 64'(m_tdata), 64'(e_md));
         chk("m_tlast_o", 64'(m_tlast), 64'(e_ml));
         chk("m_tid_o",   64'(m_tid),   64'(e_id));
      end
      // Observations taken from the DUT for the sequence-level checks
      if (rst_n && trunc) trunc_obs++;
      if (rst_n && m_tvalid && m_tready) begin
         del_obs++;
         if (m_tlast) last_obs++;
      end
      if (iso_watch >= 0 && s_tready[iso_watch]) iso_viol++;
      mdl_acc = acc;
      // Advance the model
      if (!rst_n) begin
         mq.delete();
         md_locked = 0;
         md_sel    = 0;
         md_beats  = 0;
      end else begin
         if (e_mv && m_tready) void'(mq.pop_front());
         if (acc) begin
            nb.data = s_tdata[md_sel*DW +: DW];
            nb.last = term;
            nb.id   = SW'(md_sel);
            mq.push_back(nb);
         end
         if (!md_locked) begin
            for (int i = 0; i < NR; i++) begin
               if (grant[i]) begin
                  md_sel    = i;
                  md_locked = 1;
                  md_beats  = 0;
                  break;
               end
            end
         end else if (acc) begin
            md_beats++;
            if (term) md_locked = 0;
         end
      end
   endtask

   // One cycle: check at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic clear_inputs();
      grant    = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b1;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      for (int i = 0; i < n; i++) tick();
   endtask

   // Stream nbeats from src. The grant is held only on the first cycle
   // unless keep_grant is set.
   //   bp:     stall the m side during cycles 2..8.
   //   iso:    other source that starts requesting from cycle 2.
   //   rst_at: apply a reset once rst_at beats have been accepted.
   task automatic send_pkt(input int src, input int nbeats, input bit keep_grant,
                           input bit bp, input int iso, input int rst_at);
      int k   = 0;
      int cyc = 0;
      iso_watch = iso;
      while (k < nbeats && cyc < 200) begin
         clear_inputs();
         if (cyc == 0 || keep_grant) grant[src] = 1'b1;
         s_tvalid[src]               = 1'b1;
         s_tlast[src]                = (k == nbeats - 1);
         s_tdata[src*DW +: DW]       = {8'hA0, 8'(src), 16'(k)};
         if (iso >= 0 && cyc >= 2) begin
            grant                 = '0;
            grant[iso]            = 1'b1;
            s_tvalid[iso]         = 1'b1;
            s_tdata[iso*DW +: DW] = 32'hDEAD_0000 | 32'(cyc);
         end
         m_tready = bp ? (cyc <= 1 || cyc > 8) : 1'b1;
         if (rst_at >= 0 && k == rst_at) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            break;
         end
         tick();
         if (mdl_acc) k++;
         cyc++;
      end
      iso_watch = -1;
      if (cyc >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_pkt_timeout: src %0d got %0d beats expected %0d", src, k, nbeats);
      end
   endtask

   // ---------------------------------------------------------------------
   // Directed vector table: one packet A,B,C from source 0
   // ---------------------------------------------------------------------
   typedef struct {
      logic          rst;
      logic [NR-1:0] grant;
      logic          vld;
      logic          lst;
      logic [DW-1:0] data;
      logic          mrdy;
      logic [NR-1:0] e_rdy;
      logic [NR-1:0] e_sl;
      logic          e_mv;
      logic [DW-1:0] e_md;
      logic          e_ml;
      logic          e_busy;
   } vec_t;

   vec_t vecs[7];

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      //            rst   grant    vld   lst   data          mrdy  e_rdy    e_sl     e_mv  e_md          e_ml  e_busy
      vecs[0] = '{1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[1] = '{1'b1, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0};
      vecs[2] = '{1'b1, 4'b0000, 1'b1, 1'b0, 32'hAAAA_0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b1};
      vecs[3] = '{1'b1, 4'b0000, 1'b1, 1'b0, 32'hBBBB_0002, 1'b1, 4'b0001, 4'b0000, 1'b1, 32'hAAAA_0001, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 4'b0000, 1'b1, 1'b1, 32'hCCCC_0003, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'hBBBB_0002, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0000, 4'b0000, 1'b1, 32'hCCCC_0003, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0};

      for (int v = 0; v < 7; v++) begin
         rst_n       = vecs[v].rst;
         grant       = vecs[v].grant;
         s_tvalid    = {3'b000, vecs[v].vld};
         s_tlast     = {3'b000, vecs[v].lst};
         s_tdata     = '0;
         s_tdata[DW-1:0] = vecs[v].data;
         m_tready    = vecs[v].mrdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_s_tready", v), 64'(s_tready), 64'(vecs[v].e_rdy));
         chk($sformatf("tbl%0d_s_last", v),   64'(s_last),   64'(vecs[v].e_sl));
         chk($sformatf("tbl%0d_m_tvalid", v), 64'(m_tvalid), 64'(vecs[v].e_mv));
         chk($sformatf("tbl%0d_busy", v),     64'(busy),     64'(vecs[v].e_busy));
         chk($sformatf("tbl%0d_trunc", v),    64'(trunc),    64'(1'b0));
         if (vecs[v].e_mv || !vecs[v].rst) begin
            chk($sformatf("tbl%0d_m_tdata", v), 64'(m_tdata), 64'(vecs[v].e_md));
            chk($sformatf("tbl%0d_m_tlast", v), 64'(m_tlast), 64'(vecs[v].e_ml));
            chk($sformatf("tbl%0d_m_tid", v),   64'(m_tid),   64'(0));
         end
         model_step();
         @(posedge clk);
         #1;
      end

      // Back-pressure: 5 beats, m side stalled, all beats delivered once
      del_obs = 0;
      send_pkt(0, 5, 1'b0, 1'b1, -1, -1);
      idle(4);
      chk("bp_delivered", 64'(del_obs), 64'(5));

      // Isolation: locked on src2, src3 granted and valid mid-packet
      iso_viol = 0;
      send_pkt(2, 4, 1'b0, 1'b0, 3, -1);
      chk("iso_src3_ready", 64'(iso_viol), 64'(0));
      send_pkt(3, 2, 1'b0, 1'b0, -1, -1);
      idle(4);

      // Truncation: 10 beats from src1, cut at beat 8, rest re-granted
      trunc_obs = 0;
      last_obs  = 0;
      del_obs   = 0;
      send_pkt(1, 10, 1'b1, 1'b0, -1, -1);
      idle(4);
      chk("trunc_pulses", 64'(trunc_obs), 64'(1));
      chk("trunc_lasts",  64'(last_obs),  64'(2));
      chk("trunc_beats",  64'(del_obs),   64'(10));

      // Reset after 2 of 5 beats: nothing stale afterwards
      send_pkt(0, 5, 1'b0, 1'b0, -1, 2);
      del_obs = 0;
      idle(4);
      chk("rst_stale_beats", 64'(del_obs), 64'(0));

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         int r;
         rst_n = ($urandom_range(0, 299) != 0);
         r = $urandom_range(0, 9);
         grant = '0;
         if (r >= 4 && r <= 8) grant[$urandom_range(0, NR-1)] = 1'b1;
         else if (r == 9) grant = NR'($urandom);
         s_tvalid = NR'($urandom);
         for (int k = 0; k < NR; k++) begin
            s_tlast[k]          = ($urandom_range(0, 3) == 0);
            s_tdata[k*DW +: DW] = $urandom;
         end
         m_tready = ($urandom_range(0, 9) < 7);
         tick();
      end
      rst_n = 1'b1;
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
